// File: rtl/mcpu_loader.sv
// mcpu_loader: synthesizable boot path for the MCPU instruction/data RAM.
//
// After reset or a restart, the loader clears every RAM word. It then reads a
// byte stream in this order: a header byte N (the word count), 2N data bytes
// (high byte first in each word), and one XOR checksum byte. Each word is
// written at consecutive addresses starting at 0. The CPU is released from
// reset only when the checksum matches.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (0 = reset)
//   byte_in     stream data byte
//   byte_valid  byte_in carries a byte
//   byte_ready  loader accepts a byte this cycle (decoded from state)
//   start       one-cycle pulse, restarts a load from RUN or ERR
//   mem_we      RAM write enable (registered)
//   mem_addr    RAM write address (registered)
//   mem_wdata   RAM write data (registered)
//   cpu_reset   active-high reset to the MCPU (registered)
//   done        load succeeded, CPU running (registered)
//   error       checksum mismatch (registered)
//   dbg_state   current FSM state, for checkers and debug
//
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both 1. byte_ready depends only on the current state and
// never on byte_valid. While byte_valid is 0, the FSM waits and no state
// changes.
module mcpu_loader #(
  parameter int WORD_SIZE  = 16,  // must be 16: two stream bytes per word
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_HDR   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_RUN   = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // The clear counter is one bit wider than the address. This lets it
  // reach RAM_SIZE, which marks the extra CLEAR cycle after the last clear
  // write.
  localparam int                CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  CLR_END = CNT_W'(RAM_SIZE);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              n_q, n_d;
  logic [7:0]              hi_q, hi_d;
  logic [7:0]              csum_q, csum_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic [7:0]              n_last;
  logic                    last_word;

  assign accept    = byte_valid && byte_ready;
  assign n_last    = n_q - 8'd1;
  assign last_word = (addr_q == ADDR_WIDTH'(n_last));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      addr_q      <= '0;
      n_q         <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_cnt_q == CLR_END) state_d = S_HDR;
      S_HDR:   if (accept) state_d = (byte_in == 8'd0) ? S_CSUM : S_HI;
      S_HI:    if (accept) state_d = S_LO;
      S_LO:    if (accept) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_CSUM : S_HI;
      S_CSUM:  if (accept) state_d = (byte_in == csum_q) ? S_RUN : S_ERR;
      S_RUN,
      S_ERR:   if (start) state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase
  end

  // Output and datapath logic. The memory port is registered, so each write
  // is set up one cycle early. A CLEAR write is issued on the edge after its
  // counter value is seen. A word write is issued on the edge that accepts
  // the low byte, so mem_we is high exactly during the WRITE cycle. When no
  // write is issued, the address and data registers keep their values.
  always_comb begin
    byte_ready  = (state_q == S_HDR) || (state_q == S_HI) ||
                  (state_q == S_LO)  || (state_q == S_CSUM);
    clr_cnt_d   = clr_cnt_q;
    addr_d      = addr_q;
    n_d         = n_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q != CLR_END) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = clr_cnt_q[ADDR_WIDTH-1:0];
          mem_wdata_d = '0;
          clr_cnt_d   = clr_cnt_q + CNT_W'(1);
        end
      end
      S_HDR: begin
        if (accept) begin
          n_d    = byte_in;
          csum_d = byte_in;
          addr_d = '0;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d   = byte_in;
          csum_d = csum_q ^ byte_in;
        end
      end
      S_LO: begin
        if (accept) begin
          csum_d      = csum_q ^ byte_in;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = WORD_SIZE'({hi_q, byte_in});
        end
      end
      S_WRITE: begin
        if (!last_word) addr_d = addr_q + ADDR_WIDTH'(1);
      end
      S_CSUM: begin
        if (accept) begin
          if (byte_in == csum_q) begin
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            error_d     = 1'b1;
          end
        end
      end
      S_RUN,
      S_ERR: begin
        if (start) begin
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          clr_cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mcpu_loader.md
# mcpu_loader

Program loader that sits directly upstream of the MCPU instruction/data RAM. It receives a byte stream over a valid/ready handshake, clears the RAM, and writes 16-bit instruction words from address 0. It verifies an XOR checksum and releases the CPU from reset only after a good load. This replaces hierarchical memory preloading with a synthesizable boot path.

## Interface
- WORD_SIZE, 16, RAM word width; must be 16 (two bytes per word)
- ADDR_WIDTH, 8, RAM address width
- RAM_SIZE, 256, number of RAM words cleared before loading
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- start  in  1  one-cycle pulse; restarts a load from RUN or ERR
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM write address
- mem_wdata  out  WORD_SIZE  RAM write data
- cpu_reset  out  1  active-high reset to MCPU
- done  out  1  load succeeded, CPU running
- error  out  1  checksum mismatch

## Operation
- Stream format: header byte N (word count, 0..255), then 2N data bytes with the high byte first per word, then one checksum byte. The checksum equals the XOR of the header and all data bytes.
- States:
  - CLEAR: mem_we=1, mem_wdata=0, mem_addr steps 0..RAM_SIZE-1, one word per cycle; then HDR.
  - HDR: on accept, latch N, set csum=byte, set addr=0; go to CSUM if N==0, else HI.
  - HI: on accept, latch the high byte, csum^=byte; go to LO.
  - LO: on accept, latch the low byte, csum^=byte; go to WRITE.
  - WRITE: mem_we=1 for one cycle at addr with {hi,lo}; if addr==N-1 go to CSUM, else addr++ and go to HI.
  - CSUM: on accept, go to RUN if byte==csum, else ERR.
  - RUN: cpu_reset=0, done=1.
  - ERR: cpu_reset=1, error=1.
- start is honoured only in RUN or ERR: go to CLEAR, and set cpu_reset=1, done=0, error=0. start is ignored in all other states.
- byte_ready=1 only in HDR, HI, LO and CSUM; it is decoded combinationally from state.
- A byte is accepted when byte_valid and byte_ready are both 1 at a rising edge. While byte_valid=0 the state holds and nothing changes.
- mem_we=0 in all states other than CLEAR and WRITE. mem_addr and mem_wdata are don't-care when mem_we=0 but must be stable.
- The word count never exceeds 255, so addresses never wrap. For N=255 the highest address written is 254.

## Timing
- Reset values (asynchronous, while reset=0): state CLEAR with internal address 0; mem_we=0, mem_addr=0, mem_wdata=0, byte_ready=0, cpu_reset=1, done=0, error=0, csum=0.
- First cycle after reset release: CLEAR writes address 0. The last clear write is at cycle RAM_SIZE. byte_ready rises in cycle RAM_SIZE+1.
- Each word costs at least 3 cycles: HI, LO, WRITE. byte_ready=0 during WRITE, giving one bubble per word.
- Minimum load after CLEAR: 1 + 3N + 1 cycles. cpu_reset falls and done rises on the edge that accepts a correct checksum byte.
- cpu_reset, done and error are registered outputs; done and error are never 1 together.
- Reset asserted mid-load: outputs return to their reset values immediately and a partially loaded RAM is cleared again.

## Test plan
- Reset and clear: hold reset=0, then release. Outputs at reset values; 256 writes of 0 to addresses 0..255 on consecutive cycles; then byte_ready=1.
- Single word: stream 01,12,34,27. One write {addr 0, data 0x1234}; then done=1, cpu_reset=0, error=0.
- Full program: stream N=11, the 11 Collatz program words, and the correct checksum. RAM 0..10 match the words, RAM 11..255 equal 0, and done=1.
- Bad checksum: stream 01,12,34,00. ERR state: error=1, cpu_reset=1, done=0. A start pulse then re-enters CLEAR.
- Empty load with backpressure: stream 00,00 with byte_valid toggling 1,0,0,1. No data writes; done=1 after the second accepted byte.
- Reset mid-load: assert reset after the HI byte of word 3. Outputs return to reset values; reload 01,AB,CD,67 gives RAM[0]=0xABCD, RAM[1..255]=0 and done=1.
